// File: rtl/redmule_tile_obi2axi_bridge.sv
// OBI-to-AXI4 single-beat bridge with one outstanding transaction; out-of-window requests get an OBI error with no AXI traffic.
// States: IDLE accept | WRITE AW/W pending | WAIT_B await B | READ AR pending | WAIT_R await R | RESP one-cycle rvalid.
module redmule_tile_obi2axi_bridge #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          STRB_W   = DATA_W / 8,
    parameter int unsigned          RID_W    = 1,
    parameter int unsigned          AXI_ID_W = 2,
    parameter logic [AXI_ID_W-1:0]  AXI_ID   = '0,
    parameter logic [ADDR_W-1:0]    L2_START = 32'h2000_0000,
    parameter logic [ADDR_W-1:0]    L2_END   = 32'h3000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                obi_req_i,
    output logic                obi_gnt_o,
    input  logic [ADDR_W-1:0]   obi_addr_i,
    input  logic                obi_we_i,
    input  logic [STRB_W-1:0]   obi_be_i,
    input  logic [DATA_W-1:0]   obi_wdata_i,
    input  logic [RID_W-1:0]    obi_aid_i,
    output logic                obi_rvalid_o,
    output logic [DATA_W-1:0]   obi_rdata_o,
    output logic                obi_err_o,
    output logic [RID_W-1:0]    obi_rid_o,
    output logic                aw_valid_o,
    input  logic                aw_ready_i,
    output logic [ADDR_W-1:0]   aw_addr_o,
    output logic [AXI_ID_W-1:0] aw_id_o,
    output logic [7:0]          aw_len_o,
    output logic [2:0]          aw_size_o,
    output logic [1:0]          aw_burst_o,
    output logic                aw_lock_o,
    output logic [3:0]          aw_cache_o,
    output logic [2:0]          aw_prot_o,
    output logic [3:0]          aw_qos_o,
    output logic                w_valid_o,
    input  logic                w_ready_i,
    output logic [DATA_W-1:0]   w_data_o,
    output logic [STRB_W-1:0]   w_strb_o,
    output logic                w_last_o,
    input  logic                b_valid_i,
    output logic                b_ready_o,
    input  logic [1:0]          b_resp_i,
    input  logic [AXI_ID_W-1:0] b_id_i,
    output logic                ar_valid_o,
    input  logic                ar_ready_i,
    output logic [ADDR_W-1:0]   ar_addr_o,
    output logic [AXI_ID_W-1:0] ar_id_o,
    output logic [7:0]          ar_len_o,
    output logic [2:0]          ar_size_o,
    output logic [1:0]          ar_burst_o,
    output logic                ar_lock_o,
    output logic [3:0]          ar_cache_o,
    output logic [2:0]          ar_prot_o,
    output logic [3:0]          ar_qos_o,
    input  logic                r_valid_i,
    output logic                r_ready_o,
    input  logic [DATA_W-1:0]   r_data_i,
    input  logic [1:0]          r_resp_i,
    input  logic [AXI_ID_W-1:0] r_id_i,
    input  logic                r_last_i
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_B,
        READ,
        WAIT_R,
        RESP
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [STRB_W-1:0]   be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [RID_W-1:0]    aid_q;
    logic                in_window;
    logic                unused_inputs;

    // IDs and low response bits carry nothing this bridge acts on.
    assign unused_inputs = ^{b_id_i, r_id_i, r_last_i, b_resp_i[0], r_resp_i[0]};

    assign in_window = (obi_addr_i >= L2_START) && (obi_addr_i < L2_END);
    assign obi_gnt_o = (state == IDLE) && obi_req_i && !rst_i;

    assign aw_addr_o  = addr_q;
    assign ar_addr_o  = addr_q;
    assign w_data_o   = wdata_q;
    assign w_strb_o   = be_q;
    assign w_last_o   = 1'b1;
    assign aw_id_o    = AXI_ID;
    assign ar_id_o    = AXI_ID;
    assign aw_len_o   = 8'd0;
    assign ar_len_o   = 8'd0;
    assign aw_size_o  = 3'($clog2(STRB_W));
    assign ar_size_o  = 3'($clog2(STRB_W));
    assign aw_burst_o = 2'b01;
    assign ar_burst_o = 2'b01;
    assign aw_lock_o  = 1'b0;
    assign ar_lock_o  = 1'b0;
    assign aw_cache_o = 4'd0;
    assign ar_cache_o = 4'd0;
    assign aw_prot_o  = 3'd0;
    assign ar_prot_o  = 3'd0;
    assign aw_qos_o   = 4'd0;
    assign ar_qos_o   = 4'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            aid_q        <= '0;
            aw_valid_o   <= 1'b0;
            w_valid_o    <= 1'b0;
            ar_valid_o   <= 1'b0;
            b_ready_o    <= 1'b0;
            r_ready_o    <= 1'b0;
            obi_rvalid_o <= 1'b0;
            obi_err_o    <= 1'b0;
            obi_rdata_o  <= '0;
            obi_rid_o    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (obi_gnt_o) begin
                        addr_q  <= obi_addr_i;
                        be_q    <= obi_be_i;
                        wdata_q <= obi_wdata_i;
                        aid_q   <= obi_aid_i;
                        if (!in_window) begin
                            state        <= RESP;
                            obi_rvalid_o <= 1'b1;
                            obi_err_o    <= 1'b1;
                            obi_rdata_o  <= '0;
                            obi_rid_o    <= obi_aid_i;
                        end else if (obi_we_i) begin
                            state      <= WRITE;
                            aw_valid_o <= 1'b1;
                            w_valid_o  <= 1'b1;
                        end else begin
                            state      <= READ;
                            ar_valid_o <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // A low valid doubles as the "already sent" flag for its channel.
                    if (aw_valid_o && aw_ready_i) aw_valid_o <= 1'b0;
                    if (w_valid_o && w_ready_i) w_valid_o <= 1'b0;
                    if ((!aw_valid_o || aw_ready_i) && (!w_valid_o || w_ready_i)) begin
                        state     <= WAIT_B;
                        b_ready_o <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (b_valid_i) begin
                        state        <= RESP;
                        b_ready_o    <= 1'b0;
                        obi_rvalid_o <= 1'b1;
                        obi_err_o    <= b_resp_i[1];
                        obi_rdata_o  <= '0;
                        obi_rid_o    <= aid_q;
                    end
                end
                READ: begin
                    if (ar_ready_i) begin
                        state      <= WAIT_R;
                        ar_valid_o <= 1'b0;
                        r_ready_o  <= 1'b1;
                    end
                end
                WAIT_R: begin
                    if (r_valid_i) begin
                        state        <= RESP;
                        r_ready_o    <= 1'b0;
                        obi_rvalid_o <= 1'b1;
                        obi_err_o    <= r_resp_i[1];
                        obi_rdata_o  <= r_resp_i[1] ? '0 : r_data_i;
                        obi_rid_o    <= aid_q;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    obi_rvalid_o <= 1'b0;
                    obi_err_o    <= 1'b0;
                    obi_rdata_o  <= '0;
                    obi_rid_o    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_redmule_tile_obi2axi_bridge.sv
// Bench for the OBI-to-AXI bridge: directed and random transactions against a window/latency/response model.
module tb_redmule_tile_obi2axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        obi_req, obi_gnt, obi_we, obi_aid, obi_rvalid, obi_err, obi_rid;
    logic [31:0] obi_addr, obi_wdata, obi_rdata;
    logic [3:0]  obi_be;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [31:0] aw_addr, ar_addr, w_data, r_data;
    logic [3:0]  w_strb;
    logic [1:0]  aw_id, ar_id, b_id, r_id, b_resp, r_resp;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]  aw_burst, ar_burst;
    logic        aw_lock, ar_lock;
    logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    redmule_tile_obi2axi_bridge dut (
        .clk_i(clk), .rst_i(rst),
        .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr), .obi_we_i(obi_we),
        .obi_be_i(obi_be), .obi_wdata_i(obi_wdata), .obi_aid_i(obi_aid),
        .obi_rvalid_o(obi_rvalid), .obi_rdata_o(obi_rdata), .obi_err_o(obi_err), .obi_rid_o(obi_rid),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_id_o(aw_id),
        .aw_len_o(aw_len), .aw_size_o(aw_size), .aw_burst_o(aw_burst), .aw_lock_o(aw_lock),
        .aw_cache_o(aw_cache), .aw_prot_o(aw_prot), .aw_qos_o(aw_qos),
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp), .b_id_i(b_id),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_id_o(ar_id),
        .ar_len_o(ar_len), .ar_size_o(ar_size), .ar_burst_o(ar_burst), .ar_lock_o(ar_lock),
        .ar_cache_o(ar_cache), .ar_prot_o(ar_prot), .ar_qos_o(ar_qos),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_resp_i(r_resp),
        .r_id_i(r_id), .r_last_i(r_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_slave();
        aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
        b_valid  = 1'b0; r_valid = 1'b0;
    endtask

    // One OBI transaction with the AXI side acting as a slave that waits da/dw cycles before
    // accepting AW(AR)/W and dr cycles before returning B/R. Called at a negedge, returns at a negedge.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input logic aid, input int da, input int dw,
                           input int dr, input logic [1:0] resp, input logic [31:0] rd_data,
                           input logic hold);
        logic        inw;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          a_seen = 0, w_seen = 0, rsp_seen = 0;
        int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
        int          bad = 0, cyc;
        logic        got = 1'b0;

        inw       = (addr >= 32'h2000_0000) && (addr < 32'h3000_0000);
        exp_err   = !inw || resp[1];
        exp_rdata = (inw && !we && !resp[1]) ? rd_data : 32'h0;
        exp_lat   = !inw ? 1 : (we ? 3 + ((da > dw) ? da : dw) + dr : 3 + da + dr);

        obi_req = 1'b1; obi_addr = addr; obi_we = we; obi_be = be; obi_wdata = wdata; obi_aid = aid;
        idle_slave();
        #1;
        chk("gnt_idle", obi_gnt, 1);
        @(posedge clk); @(negedge clk);
        if (!hold) obi_req = 1'b0;
        cyc = 1;
        while (!got && cyc < 200) begin
            idle_slave();
            if (obi_req && obi_gnt) bad++;
            if (obi_rvalid) begin
                got = 1'b1;
            end else begin
                if (aw_valid) begin
                    if (aw_addr !== addr || aw_id !== 2'd0) bad++;
                    if (a_seen >= da) begin aw_ready = 1'b1; aw_hs++; end
                    a_seen++;
                end
                if (w_valid) begin
                    if (w_data !== wdata || w_strb !== be || w_last !== 1'b1) bad++;
                    if (w_seen >= dw) begin w_ready = 1'b1; w_hs++; end
                    w_seen++;
                end
                if (ar_valid) begin
                    if (ar_addr !== addr || ar_id !== 2'd0) bad++;
                    if (a_seen >= da) begin ar_ready = 1'b1; ar_hs++; end
                    a_seen++;
                end
                if (b_ready) begin
                    if (rsp_seen >= dr) begin
                        b_valid = 1'b1; b_resp = resp; b_id = 2'($urandom_range(3)); b_hs++;
                    end
                    rsp_seen++;
                end else if ($urandom_range(3) == 0) begin
                    b_valid = 1'b1; b_resp = 2'b10;
                end
                if (r_ready) begin
                    if (rsp_seen >= dr) begin
                        r_valid = 1'b1; r_resp = resp; r_data = rd_data; r_last = 1'b1;
                        r_id = 2'($urandom_range(3)); r_hs++;
                    end
                    rsp_seen++;
                end else if ($urandom_range(3) == 0) begin
                    r_valid = 1'b1; r_resp = 2'b00; r_data = $urandom;
                end
                @(posedge clk); @(negedge clk);
                cyc++;
            end
        end
        chk("rvalid_seen", 32'(got), 1);
        chk("latency", cyc, exp_lat);
        chk("err", 32'(obi_err), 32'(exp_err));
        chk("rdata", obi_rdata, exp_rdata);
        chk("rid", 32'(obi_rid), 32'(aid));
        chk("aw_count", aw_hs, 32'(inw && we));
        chk("w_count", w_hs, 32'(inw && we));
        chk("ar_count", ar_hs, 32'(inw && !we));
        chk("resp_count", b_hs + r_hs, 32'(inw));
        chk("axi_fields_gnt", bad, 0);
        idle_slave();
        @(posedge clk); @(negedge clk);
        chk("rvalid_pulse", 32'(obi_rvalid), 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] bnd [4];
        bnd[0] = 32'h2000_0000; bnd[1] = 32'h2FFF_FFFC; bnd[2] = 32'h3000_0000; bnd[3] = 32'h1FFF_FFFC;

        rst = 1'b1; obi_req = 1'b0; obi_addr = '0; obi_we = 1'b0; obi_be = '0; obi_wdata = '0; obi_aid = 1'b0;
        b_resp = '0; b_id = '0; r_data = '0; r_resp = '0; r_id = '0; r_last = 1'b0;
        idle_slave();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {obi_gnt, obi_rvalid, obi_err, obi_rid, aw_valid, w_valid, ar_valid,
                              b_ready, r_ready}, 0);
        chk("reset_rdata", obi_rdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("fixed_aw", {aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos},
            {8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0});
        chk("fixed_ar", {ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos},
            {8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0});

        run_txn(32'h2000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 1'b0);
        run_txn(32'h2000_0004, 1'b1, 4'b0011, 32'h1234_5678, 1'b1, 0, 3, 1, 2'b00, 32'h0, 1'b0);
        run_txn(32'h1000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 0, 0, 0, 2'b00, 32'h5555_AAAA, 1'b0);
        run_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, 1'b1, 0, 0, 0, 2'b00, 32'h5555_AAAA, 1'b0);
        run_txn(32'h2000_0100, 1'b0, 4'hF, 32'h0, 1'b1, 1, 0, 2, 2'b10, 32'hCAFE_F00D, 1'b0);
        run_txn(32'h2000_0200, 1'b1, 4'hF, 32'hA5A5_5A5A, 1'b0, 2, 0, 0, 2'b11, 32'h0, 1'b0);
        run_txn(32'h2FFF_FFFC, 1'b0, 4'hF, 32'h0, 1'b0, 0, 0, 0, 2'b00, 32'h0BAD_CAFE, 1'b1);
        run_txn(32'h2000_0020, 1'b1, 4'b1100, 32'h7777_8888, 1'b1, 1, 2, 0, 2'b00, 32'h0, 1'b0);

        // Reset while waiting on R abandons the read.
        obi_req = 1'b1; obi_addr = 32'h2000_0040; obi_we = 1'b0; obi_aid = 1'b1;
        @(posedge clk); @(negedge clk);
        obi_req = 1'b0; ar_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        ar_ready = 1'b0;
        chk("r_ready_before_rst", 32'(r_ready), 1);
        rst = 1'b1; obi_req = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_outputs", {obi_gnt, obi_rvalid, obi_err, obi_rid, aw_valid, w_valid, ar_valid,
                            b_ready, r_ready}, 0);
        chk("rst_rdata", obi_rdata, 0);
        rst = 1'b0; obi_req = 1'b0;
        begin
            int spurious = 0;
            for (int i = 0; i < 5; i++) begin
                r_valid = 1'b1; r_data = 32'h1111_2222; r_resp = 2'b00;
                if (obi_rvalid || r_ready) spurious++;
                @(posedge clk); @(negedge clk);
            end
            r_valid = 1'b0;
            chk("no_resp_after_rst", spurious, 0);
        end
        run_txn(32'h2000_0044, 1'b0, 4'hF, 32'h0, 1'b0, 0, 0, 1, 2'b00, 32'h600D_D474, 1'b0);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(2))
                0:       a = $urandom;
                1:       a = 32'h2000_0000 + ($urandom & 32'h0FFF_FFFC);
                default: a = bnd[$urandom_range(3)];
            endcase
            run_txn(a, 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom, 1'($urandom_range(1)),
                    $urandom_range(3), $urandom_range(3), $urandom_range(3),
                    2'($urandom_range(3)), $urandom, (i != 29) ? 1'($urandom_range(1)) : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
